// File: rtl/dram_ctrl_pkg.sv
// dram_ctrl_pkg: shared types and default sizing for the dram controller slice.
// Contents: controller state enum, default widths, read latency and refresh timing.
// Optional feature macro used by the top: DRAM_CTRL_STATS_EN (state-entry statistics).
package dram_ctrl_pkg;

  localparam int DEF_DATA_W         = 8;
  localparam int DEF_ADDR_W         = 4;
  localparam int DEF_READ_LAT       = 1;   // legal 1..4
  localparam int DEF_REFRESH_PERIOD = 64;  // must be >= 8
  localparam int DEF_REFRESH_CYCLES = 2;   // legal 1..15

  // One shared down-counter serves both read latency and refresh length.
  localparam int LAT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RWAIT,
    REFRESH
  } state_e;

endpackage

// File: rtl/dram_ctrl_if.sv
// dram_ctrl_if: host request/response channel plus dram array pins.
// Parameters DATA_W, ADDR_W. Modport slave = controller view,
// modport master = host + array view (drives requests and mem_rdata).
interface dram_ctrl_if
  import dram_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  // host side
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;

  // array side
  logic              mem_wr;
  logic              mem_rd;
  logic              mem_ref;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output mem_wr, mem_rd, mem_ref, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_wr, mem_rd, mem_ref, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dram_refresh_timer.sv
// dram_refresh_timer: free-running period counter raising a sticky refresh request.
// Latency: ref_pending_o rises the edge the counter wraps; clears the edge ref_ack_i is seen.
// Backpressure: none; a wrap while a request is already pending is absorbed (no queueing).
// Ports: clk, rst (async active-high), ref_ack_i (controller entering REFRESH), ref_pending_o.
module dram_refresh_timer
  import dram_ctrl_pkg::*;
#(
  parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic ref_ack_i,
  output logic ref_pending_o
);

  localparam int CNT_W = $clog2(REFRESH_PERIOD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             wrap;

  always_comb begin
    wrap   = (cnt_q == CNT_MAX);
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    pend_d = pend_q;
    if (wrap) begin
      pend_d = 1'b1;
    end
    // Ack wins: a wrap landing on the ack edge is the absorbed duplicate.
    if (ref_ack_i) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign ref_pending_o = pend_q;

endmodule

// File: rtl/dram_ctrl.sv
// dram_ctrl: initiator-side controller for a single-port dram array with periodic refresh.
// Latency: write strobe the cycle after accept; resp_valid READ_LAT+1 edges after a read accept.
// Backpressure: req_ready low while busy or a refresh is pending; refresh never aborts a request.
// Ports: clk, rst (async active-high), bus (dram_ctrl_if.slave: host req/resp + array pins).
// Optional: define DRAM_CTRL_STATS_EN to add stat_wr/stat_rd/stat_ref saturating entry counters.
module dram_ctrl
  import dram_ctrl_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int READ_LAT       = DEF_READ_LAT,
  parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD,
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  dram_ctrl_if.slave  bus
`ifdef DRAM_CTRL_STATS_EN
  ,
  output logic [15:0] stat_wr,
  output logic [15:0] stat_rd,
  output logic [15:0] stat_ref
`endif
);

  state_e            state_q;
  logic              mem_wr_q, mem_rd_q, mem_ref_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic [LAT_W-1:0]  lat_q;

  logic ref_pending;
  logic ref_ack;
  logic req_ready;
  logic accept;

  assign req_ready = (state_q == IDLE) && !ref_pending;
  assign accept    = bus.req_valid && req_ready;
  assign ref_ack   = (state_q == IDLE) && ref_pending;

  dram_refresh_timer #(
    .REFRESH_PERIOD (REFRESH_PERIOD)
  ) u_refresh_timer (
    .clk           (clk),
    .rst           (rst),
    .ref_ack_i     (ref_ack),
    .ref_pending_o (ref_pending)
  );

  // Strobes are registered: the accept edge loads the state and the strobe together,
  // so the strobe is high exactly for the one cycle the FSM sits in WRITE/READ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_wr_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_ref_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      lat_q        <= '0;
    end else begin
      mem_wr_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ref_pending) begin
            state_q   <= REFRESH;
            mem_ref_q <= 1'b1;
            lat_q     <= LAT_W'(REFRESH_CYCLES - 1);
          end else if (accept) begin
            mem_addr_q <= bus.req_addr;
            if (bus.req_we) begin
              state_q     <= WRITE;
              mem_wr_q    <= 1'b1;
              mem_wdata_q <= bus.req_wdata;
            end else begin
              state_q  <= READ;
              mem_rd_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          state_q <= IDLE;
        end
        READ: begin
          state_q <= RWAIT;
          lat_q   <= LAT_W'(READ_LAT);
        end
        RWAIT: begin
          if (lat_q == LAT_W'(1)) begin
            resp_rdata_q <= bus.mem_rdata;
            resp_valid_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        REFRESH: begin
          if (lat_q == '0) begin
            mem_ref_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_rd     = mem_rd_q;
  assign bus.mem_ref    = mem_ref_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

`ifdef DRAM_CTRL_STATS_EN
  // Entry events match the FSM decisions taken in IDLE.
  logic ent_wr, ent_rd;
  assign ent_wr = accept && bus.req_we;
  assign ent_rd = accept && !bus.req_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_wr  <= '0;
      stat_rd  <= '0;
      stat_ref <= '0;
    end else begin
      if (ent_wr && (stat_wr != 16'hFFFF)) begin
        stat_wr <= stat_wr + 16'd1;
      end
      if (ent_rd && (stat_rd != 16'hFFFF)) begin
        stat_rd <= stat_rd + 16'd1;
      end
      if (ref_ack && (stat_ref != 16'hFFFF)) begin
        stat_ref <= stat_ref + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl: self-checking bench for dram_ctrl with a behavioural dram array.
// Directed vector table + hand sequences, then random traffic against a scoreboard.
module tb_dram_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int RL = 1;
  localparam int RP = 64;
  localparam int RC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dram_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

`ifdef DRAM_CTRL_STATS_EN
  logic [15:0] stat_wr, stat_rd, stat_ref;
`endif

  dram_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .READ_LAT(RL),
    .REFRESH_PERIOD(RP), .REFRESH_CYCLES(RC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DRAM_CTRL_STATS_EN
    ,
    .stat_wr  (stat_wr),
    .stat_rd  (stat_rd),
    .stat_ref (stat_ref)
`endif
  );

  // behavioural single-port dram, one-cycle read latency
  logic [DW-1:0] mem [16];
  logic [DW-1:0] dram_out;
  always @(posedge clk) begin
    if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd) dram_out <= mem[bus.mem_addr];
  end
  assign bus.mem_rdata = dram_out;

  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            known;
    int            due;
  } exp_t;

  exp_t          wq[$];
  exp_t          rq[$];
  exp_t          e;
  logic [DW-1:0] shadow [16];
  bit            shadow_ok [16];
  int            cyc = 0;       // edges since reset release
  logic [DW-1:0] resp_log[$];

  // Accepts sampled with pre-edge values; expectations derived from the protocol rules.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0;
      wq.delete();
      rq.delete();
    end else begin
      cyc++;
      if (bus.req_valid && bus.req_ready) begin
        e.a = bus.req_addr;
        if (bus.req_we) begin
          shadow[bus.req_addr]    = bus.req_wdata;
          shadow_ok[bus.req_addr] = 1'b1;
          e.d = bus.req_wdata; e.known = 1'b1; e.due = cyc;
          wq.push_back(e);
        end else begin
          e.d = shadow[bus.req_addr]; e.known = shadow_ok[bus.req_addr];
          e.due = cyc + RL + 1;
          rq.push_back(e);
        end
      end
    end
  end

  logic prev_resp = 1'b0;
  logic prev_ref  = 1'b0;
  int   ref_seen  = 0;
  int   ref_run   = 0;
  int   t_req;

  always @(negedge clk) begin
    if (rst) begin
      prev_resp = 1'b0; prev_ref = 1'b0; ref_seen = 0; ref_run = 0;
    end else begin
      chk("strobe_excl", ($countones({bus.mem_wr, bus.mem_rd, bus.mem_ref}) <= 1), 1);
      if (bus.resp_valid) chk("resp_b2b", prev_resp, 0);
      // write strobes
      if (bus.mem_wr) begin
        chk("sb_wr_expected", (wq.size() != 0), 1);
        if (wq.size() != 0) begin
          chk("sb_wr_addr", bus.mem_addr, wq[0].a);
          chk("sb_wr_data", bus.mem_wdata, wq[0].d);
          chk("sb_wr_time", cyc, wq[0].due);
          void'(wq.pop_front());
        end
      end else if (wq.size() != 0 && cyc > wq[0].due) begin
        chk("sb_wr_missing", 0, 1);
        void'(wq.pop_front());
      end
      // read responses
      if (bus.resp_valid) begin
        resp_log.push_back(bus.resp_rdata);
        chk("sb_rd_expected", (rq.size() != 0), 1);
        if (rq.size() != 0) begin
          if (rq[0].known) chk("sb_rd_data", bus.resp_rdata, rq[0].d);
          chk("sb_rd_time", cyc, rq[0].due);
          void'(rq.pop_front());
        end
      end else if (rq.size() != 0 && cyc > rq[0].due) begin
        chk("sb_rd_missing", 0, 1);
        void'(rq.pop_front());
      end
      // refresh: request at every multiple of RP, served within RL+2 edges
      t_req = (ref_seen + 1) * RP;
      if (bus.mem_ref && !prev_ref) begin
        chk("ref_start_window", (cyc > t_req) && (cyc <= t_req + RL + 2), 1);
        ref_seen++;
        ref_run = 1;
      end else if (bus.mem_ref) begin
        ref_run++;
      end else if (prev_ref) begin
        chk("ref_run_len", ref_run, RC);
      end else if (cyc > t_req + RL + 2) begin
        chk("ref_overdue", 0, 1);
        ref_seen++;
      end
      prev_resp = bus.resp_valid;
      prev_ref  = bus.mem_ref;
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef struct {
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp;   // expected mem_wdata (write) or resp_rdata (read)
  } vec_t;

  vec_t vecs[12];

  // Present a request at a negedge; return at the negedge after the accept edge.
  task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit hold);
    int w = 0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
    while (!bus.req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", (w < 200), 1);
    if (w >= 200) begin
      bus.req_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      if (!hold) bus.req_valid = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v);
    issue(v.we, v.a, v.d, 1'b0);
    chk("tbl_ready_busy", bus.req_ready, 0);
    chk("tbl_addr", bus.mem_addr, v.a);
    if (v.we) begin
      chk("tbl_wr_hi", bus.mem_wr, 1);
      chk("tbl_wdata", bus.mem_wdata, v.exp);
      @(negedge clk);
      chk("tbl_wr_lo", bus.mem_wr, 0);
    end else begin
      chk("tbl_rd_hi", bus.mem_rd, 1);
      repeat (RL) begin
        @(negedge clk);
        chk("tbl_resp_early", bus.resp_valid, 0);
      end
      @(negedge clk);
      chk("tbl_resp_hi", bus.resp_valid, 1);
      chk("tbl_rdata", bus.resp_rdata, v.exp);
      chk("tbl_ready_back", bus.req_ready, 1);
      @(negedge clk);
      chk("tbl_resp_lo", bus.resp_valid, 0);
    end
  endtask

  int n, ref_len, acc_cyc, base;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 4'd3,  8'hFF, 8'hFF};
    vecs[1]  = '{1'b0, 4'd3,  8'h00, 8'hFF};
    vecs[2]  = '{1'b1, 4'd2,  8'h11, 8'h11};
    vecs[3]  = '{1'b1, 4'd9,  8'hC3, 8'hC3};
    vecs[4]  = '{1'b0, 4'd2,  8'h00, 8'h11};
    vecs[5]  = '{1'b0, 4'd9,  8'h00, 8'hC3};
    vecs[6]  = '{1'b1, 4'd15, 8'h80, 8'h80};
    vecs[7]  = '{1'b0, 4'd15, 8'h00, 8'h80};
    vecs[8]  = '{1'b1, 4'd2,  8'hEE, 8'hEE};
    vecs[9]  = '{1'b0, 4'd2,  8'h00, 8'hEE};
    vecs[10] = '{1'b0, 4'd3,  8'h00, 8'hFF};
    vecs[11] = '{1'b1, 4'd0,  8'h01, 8'h01};

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    // reset
    #10 rst = 1'b0;
    #1;
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_wr", bus.mem_wr, 0);
    chk("rst_rd", bus.mem_rd, 0);
    chk("rst_ref", bus.mem_ref, 0);
    chk("rst_resp", bus.resp_valid, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_rdata", bus.resp_rdata, 0);
    @(negedge clk);

    // write 3 <- FF, then read it back
    run_vec(vecs[0]);
    chk("wr_ready_after", bus.req_ready, 1);
    run_vec(vecs[1]);

    // refresh pre-empts a request presented once the first wrap has landed
    n = 0;
    while (cyc < RP && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ref_wait_cyc", cyc, RP);
    chk("ref_pend_ready", bus.req_ready, 0);
    chk("ref_not_yet", bus.mem_ref, 0);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'd5; bus.req_wdata = 8'h77;
    ref_len = 0; acc_cyc = -1;
    for (int k = 0; k < 12 && acc_cyc < 0; k++) begin
      @(negedge clk);
      if (bus.mem_ref) ref_len++;
      if (bus.req_ready) acc_cyc = cyc + 1;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("ref_len", ref_len, RC);
    chk("ref_accept_cyc", acc_cyc, RP + RC + 2);
    chk("ref_wr_after", bus.mem_wr, 1);
    chk("ref_wr_addr", bus.mem_addr, 5);
    chk("ref_wr_no_overlap", bus.mem_ref, 0);
    @(negedge clk);

    // vector table
    for (int i = 2; i < 12; i++) run_vec(vecs[i]);

    // back-to-back stream with req_valid held
    base = resp_log.size();
    issue(1'b1, 4'd0, 8'hA5, 1'b1);
    issue(1'b1, 4'd1, 8'h5A, 1'b1);
    issue(1'b0, 4'd0, 8'h00, 1'b1);
    issue(1'b0, 4'd1, 8'h00, 1'b0);
    n = 0;
    while (resp_log.size() < base + 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_count", resp_log.size() - base, 2);
    if (resp_log.size() >= base + 2) begin
      chk("b2b_first", resp_log[base], 8'hA5);
      chk("b2b_second", resp_log[base + 1], 8'h5A);
    end

    // reset during READ (ph 0) and during RWAIT (ph 1)
    for (int ph = 0; ph < 2; ph++) begin
      issue(1'b0, 4'd3, 8'h00, 1'b0);
      if (ph == 1) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mr_rd_low", bus.mem_rd, 0);
      chk("mr_resp_low", bus.resp_valid, 0);
      chk("mr_addr_zero", bus.mem_addr, 0);
      chk("mr_ready", bus.req_ready, 1);
      @(negedge clk);
      chk("mr_no_resp_held", bus.resp_valid, 0);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("mr_no_resp_after", bus.resp_valid, 0);
      chk("mr_ready_after", bus.req_ready, 1);
      run_vec(vecs[1]);
    end

    // random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
            ($urandom_range(0, 3) != 0));
      if (!bus.req_valid) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bus.req_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("sb_wq_drained", wq.size(), 0);
    chk("sb_rq_drained", rq.size(), 0);
    chk("ref_seen_count", (ref_seen >= (cyc / RP) - 1) && (ref_seen <= cyc / RP), 1);

`ifdef DRAM_CTRL_STATS_EN
    chk("stats_counting", (stat_wr != 0) && (stat_rd != 0) && (stat_ref != 0), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
